// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer_pkg
// Description : Board-common timing constants for pushbutton/switch
//               conditioning, plus a width helper for cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

    // 20 ms of stability at a 50 MHz system clock
    localparam int DEBOUNCE_20MS_50MHZ  = 1000000;

    // Auto-repeat defaults at 50 MHz: 500 ms first repeat, then every 100 ms
    localparam int REPEAT_DELAY_DEFAULT = 25000000;
    localparam int REPEAT_RATE_DEFAULT  = 5000000;

    // Bits needed to hold any value in 0..max_val
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debouncer_bit.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer_bit
// Description : One debounced channel: two-flop synchronizer, stable-run
//               counter, registered level and one-cycle rise/fall pulses.
//               Optional auto-repeat of rise while held, enabled by the
//               macro INPUT_DEBOUNCER_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer_bit
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int CNT_W           = 20,
`ifdef INPUT_DEBOUNCER_REPEAT_EN
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEFAULT,
`endif
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Physical pin level when nothing is pressed
    localparam logic             c_idle_pin = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_x;
    logic             w_accept;

`ifdef INPUT_DEBOUNCER_REPEAT_EN
    localparam int                 c_rpt_w      = count_width(REPEAT_DELAY);
    localparam logic [c_rpt_w-1:0] c_rpt_last   = c_rpt_w'(REPEAT_DELAY - 1);
    // Reloading here makes the next repeat land REPEAT_RATE cycles later
    localparam logic [c_rpt_w-1:0] c_rpt_reload = c_rpt_w'(REPEAT_DELAY - REPEAT_RATE);

    logic [c_rpt_w-1:0] r_rpt;
`endif

    // Logical sample: 1 means asserted regardless of pin polarity
    assign w_x      = r_s2 ^ ACTIVE_LOW;
    // The disagreement has lasted long enough to become the new level
    assign w_accept = (w_x != r_level) && (r_cnt == c_cnt_last);

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= c_idle_pin;
            r_s2 <= c_idle_pin;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Stable-run counter, accepted level and edge pulses (plus optional repeat)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
`ifdef INPUT_DEBOUNCER_REPEAT_EN
            r_rpt   <= '0;
`endif
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_x == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_x;
                r_cnt   <= '0;
                r_rise  <= w_x;
                r_fall  <= ~w_x;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
`ifdef INPUT_DEBOUNCER_REPEAT_EN
            // Repeat timing restarts on every accepted change and idles while released
            if (w_accept || !r_level) begin
                r_rpt <= '0;
            end else if (r_rpt == c_rpt_last) begin
                r_rise <= 1'b1;
                r_rpt  <= c_rpt_reload;
            end else begin
                r_rpt <= r_rpt + 1'b1;
            end
`endif
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Multi-channel synchronizer/debouncer for board pushbuttons
//               and switches. Each channel is an independent
//               input_debouncer_bit. Optional auto-repeat on rise is
//               enabled by the macro INPUT_DEBOUNCER_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int CNT_W           = 20,
`ifdef INPUT_DEBOUNCER_REPEAT_EN
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEFAULT,
`endif
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset_N,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_chan
            input_debouncer_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
`ifdef INPUT_DEBOUNCER_REPEAT_EN
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
`endif
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_bit (
                .clk     (SI_ClkIn),
                .rst_n   (SI_Reset_N),
                .i_raw   (raw_in[g]),
                .o_level (level[g]),
                .o_rise  (rise[g]),
                .o_fall  (fall[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4,
//               WIDTH=4, active-low pins). Expected pulses are queued when
//               stimulus is driven and compared when the DUT pulses.
//               Repeat checks follow INPUT_DEBOUNCER_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int DEB = 4;
    // Clean change driven after cycle N is accepted on edge N+1+(DEB+1)
    localparam int LAT = DEB + 2;
`ifdef INPUT_DEBOUNCER_REPEAT_EN
    localparam int RPT_DELAY = 8;
    localparam int RPT_RATE  = 3;
`endif

    typedef struct {
        int         t;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] level;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_in;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;

    evt_t       q[$];
    int         cyc       = 0;
    int         total     = 0;
    int         bad       = 0;
    logic       mon_en    = 1'b0;
    logic [3:0] exp_level = 4'h0;

    input_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
`ifdef INPUT_DEBOUNCER_REPEAT_EN
        .REPEAT_DELAY    (RPT_DELAY),
        .REPEAT_RATE     (RPT_RATE),
`endif
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .raw_in     (raw_in),
        .level      (level),
        .rise       (rise),
        .fall       (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after edge j, cyc == j
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic push_evt(input int t, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
        evt_t e;
        e.t = t; e.rise = r; e.fall = f; e.level = l;
        q.push_back(e);
    endtask

    // Expected events for a clean press of mask m driven at cycle t0, released hold cycles later
    task automatic sched(input logic [3:0] m, input int t0, input int hold);
        int t_r;
        int t_f;
        t_r = t0 + LAT;
        t_f = t0 + hold + LAT;
        push_evt(t_r, m, 4'h0, m);
`ifdef INPUT_DEBOUNCER_REPEAT_EN
        for (int t = t_r + RPT_DELAY; t < t_f; t += RPT_RATE)
            push_evt(t, m, 4'h0, m);
`endif
        push_evt(t_f, 4'h0, m, 4'h0);
    endtask

    // Per-cycle observation at the falling edge
    task automatic mon_cycle();
        evt_t e;
        check_eq("rise_fall_overlap", 32'(rise & fall), 32'h0);
        if ((rise | fall) != 4'h0) begin
            if (q.size() == 0) begin
                check_eq("unexpected_pulse", {24'h0, rise, fall}, 32'h0);
            end else begin
                e = q.pop_front();
                check_eq("pulse_cycle", 32'(cyc), 32'(e.t));
                check_eq("pulse_rise", 32'(rise), 32'(e.rise));
                check_eq("pulse_fall", 32'(fall), 32'(e.fall));
                check_eq("pulse_level", 32'(level), 32'(e.level));
                exp_level = e.level;
            end
        end else begin
            if (q.size() != 0 && q[0].t <= cyc) begin
                e = q.pop_front();
                check_eq("missed_pulse", {24'h0, rise, fall}, {24'h0, e.rise, e.fall});
                exp_level = e.level;
            end
            check_eq("steady_level", 32'(level), 32'(exp_level));
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mon_en) mon_cycle();
            else        exp_level = 4'h0;
        end
    endtask

    task automatic do_press(input logic [3:0] m, input int hold);
        raw_in = ~m;
        sched(m, cyc, hold);
        step(hold);
        raw_in = 4'hF;
        step(14);
    endtask

    initial begin
        rst_n  = 1'b0;
        raw_in = 4'hF;
        step(3);
        check_eq("reset_level", 32'(level), 32'h0);
        check_eq("reset_rise", 32'(rise), 32'h0);
        check_eq("reset_fall", 32'(fall), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(20);

        // Single channel press and release
        do_press(4'h1, 12);

        // Bounce on channel 1: low 3, high 1 (just before acceptance), then low held
        raw_in = 4'hD;
        step(3);
        raw_in = 4'hF;
        step(1);
        raw_in = 4'hD;
        sched(4'h2, cyc, 12);
        step(12);
        raw_in = 4'hF;
        step(14);

        // All channels at once
        do_press(4'hF, 20);

        // Reset mid-count on channel 2 while channel 0 is already accepted
        raw_in = 4'hE;
        push_evt(cyc + LAT, 4'h1, 4'h0, 4'h1);
        step(8);
        raw_in = 4'hA;
        step(4);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_eq("async_rst_level", 32'(level), 32'h0);
        check_eq("async_rst_rise", 32'(rise), 32'h0);
        check_eq("async_rst_fall", 32'(fall), 32'h0);
        step(2);
        rst_n  = 1'b1;
        sched(4'h5, cyc, 10);
        mon_en = 1'b1;
        step(10);
        raw_in = 4'hF;
        step(14);

        // Long hold on channel 3 (auto-repeat when enabled)
        do_press(4'h8, 40);

        check_eq("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
